ws2812_arbiter: RTL and testbench
=================================

WS2812_ARBITER -- requirements
Module: ws2812_arbiter

Interface
Parameters
REQ-001 The block SHALL have parameter CLK_FRE, default 32_000_000; clock frequency in Hz.
REQ-002 The block SHALL have parameter HOLD_MS, default 200; minimum display time in ms after a grant's request drops.
REQ-003 The block SHALL have parameter BLINK_MS, default 250; half-period of blink in ms.

Ports
REQ-004 The block SHALL have these ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  4  level requests; req[3] is highest priority.
- color0..color3  input  24 each  GRB colour per requester.
- blink  input  4  per-requester blink enable.
- dim  input  2  global brightness shift, 0 = full.
- color  output  24  colour for the WS2812 driver.
- grant  output  2  index of the displayed requester.
- grant_valid  output  1  high when a requester is displayed.

Function
REQ-005 The block SHALL derive a 1 ms tick from a counter that wraps at CLK_FRE/1000-1; the tick is high for one cycle at the wrap.
REQ-006 The block SHALL implement states IDLE, ACTIVE and LINGER.
REQ-007 In IDLE with req==0, the block SHALL hold color=0 and grant_valid=0.
REQ-008 In IDLE with any req bit set, the block SHALL grant the highest set index and enter ACTIVE on the next clock.
REQ-009 In ACTIVE, when req[grant] drops, the block SHALL load the hold counter with HOLD_MS and enter LINGER.
REQ-010 In ACTIVE or LINGER, a set req bit with index greater than grant SHALL preempt immediately: grant moves to that index, the state becomes ACTIVE, the hold counter clears and the blink phase resets.
REQ-011 In LINGER, the hold counter SHALL decrement once per ms tick.
REQ-012 In LINGER, on reaching 0 the block SHALL move to the highest pending request (state ACTIVE), or to IDLE if none is pending.
REQ-013 In LINGER, if req[grant] reasserts, the block SHALL return to ACTIVE and keep the same grant.
REQ-014 Lower-priority requests SHALL never preempt; they wait until the current grant leaves ACTIVE and LINGER.
REQ-015 A single grant change and a tick in the same cycle SHALL be resolved with preemption taking precedence; the tick is ignored for the hold counter that cycle.
REQ-016 Blink phase:
- A phase bit toggles every BLINK_MS ticks.
- The phase resets to "on" with a cleared ms sub-count on every grant change.
- When blink[grant]=1 and the phase is "off", color=0.
REQ-017 Dimming: each 8-bit colour byte SHALL be logically right-shifted by dim, with no rounding; dim=3 on 0xFF gives 0x1F.
REQ-018 color, grant and grant_valid SHALL be registered, updating one clock after the state or phase change that causes them.
REQ-019 color SHALL remain stable between changes, so the downstream driver only resends on real colour changes.
REQ-020 Changes to the colorN, blink and dim inputs SHALL reach color within one clock, with no state change.
REQ-021 All counters SHALL be sized for their parameter maxima, and SHALL saturate or wrap only as specified.

Reset
REQ-022 While reset_n=0, the block SHALL asynchronously force state=IDLE, color=0, grant=0, grant_valid=0, and clear the ms counter, hold counter, blink counter and phase (phase = "on").
REQ-023 Deasserting reset_n mid-operation and re-asserting req SHALL restart arbitration from IDLE, with no residual hold time.

Verification (CLK_FRE=1_000_000, HOLD_MS=10, BLINK_MS=4)
REQ-024 Scenario: req=0001, color0=0x00FF00 -> after 2 clocks color=0x00FF00, grant=0, grant_valid=1.
REQ-025 Scenario: with grant 0 active, req=0101, color2=0x0000FF -> next clock grant=2, color=0x0000FF (preemption).
REQ-026 Scenario: grant 2, req drops to 0000 -> color stays 0x0000FF for 10 ms ±1 tick, then color=0 and grant_valid=0.
REQ-027 Scenario: grant 2 lingering, req=0001 -> grant 2 is kept for the full 10 ms, then grant=0.
REQ-028 Scenario: blink[0]=1, req=0001 -> color alternates 0x00FF00 and 0 every 4000 clocks, starting "on".
REQ-029 Scenario: dim=2, color0=0xFF8040 -> color=0x3F2010.
REQ-030 Scenario: reset_n pulsed low during LINGER -> immediately color=0 and grant_valid=0; after release with req=0, the block stays in IDLE.

Source files
------------

// File: rtl/ws2812_arbiter.sv
// ws2812_arbiter
// Arbitrates four level requesters for a single WS2812 colour output.
// Highest index wins and preempts lower ones. A released grant keeps
// its colour for HOLD_MS. Optional per-requester blink and a global
// brightness shift are applied before the registered colour output.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   req[3:0]              - level requests, req[3] highest priority
//   color0..color3[23:0]  - GRB colour per requester
//   blink[3:0]            - per-requester blink enable
//   dim[1:0]              - right shift applied to every colour byte
//   color[23:0]           - registered colour for the WS2812 driver
//   grant[1:0]            - registered index of the displayed requester
//   grant_valid           - registered, high while a requester is displayed
module ws2812_arbiter #(
    parameter int CLK_FRE  = 32_000_000,
    parameter int HOLD_MS  = 200,
    parameter int BLINK_MS = 250
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [23:0] color0,
    input  logic [23:0] color1,
    input  logic [23:0] color2,
    input  logic [23:0] color3,
    input  logic [3:0]  blink,
    input  logic [1:0]  dim,
    output logic [23:0] color,
    output logic [1:0]  grant,
    output logic        grant_valid
);

    localparam int MS_DIV  = ((CLK_FRE / 1000) > 1) ? (CLK_FRE / 1000) : 2;
    localparam int MS_W    = $clog2(MS_DIV);
    localparam int HOLD_W  = (HOLD_MS > 0) ? $clog2(HOLD_MS + 1) : 1;
    localparam int BLINK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    localparam logic [MS_W-1:0]    MS_MAX    = MS_W'(MS_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_MS);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'((BLINK_MS > 0) ? (BLINK_MS - 1) : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        LINGER = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [MS_W-1:0]     ms_q, ms_d;
    logic [BLINK_W-1:0]  blk_q, blk_d;
    logic                phase_q, phase_d;      // 1 = "on"
    logic [23:0]         color_q, color_d;
    logic [1:0]          grant_q, grant_d;
    logic                valid_q, valid_d;

    logic                tick_s;
    logic                any_s;
    logic                higher_s;
    logic                restart_s;             // grant change: restart blink timing
    logic [1:0]          top_s;
    logic [23:0]         raw_s;

    // Index of the highest set request bit (0 when none set).
    function automatic logic [1:0] top_index(input logic [3:0] r);
        logic [1:0] idx;
        if (r[3]) begin
            idx = 2'd3;
        end else if (r[2]) begin
            idx = 2'd2;
        end else if (r[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    // Logical right shift of each GRB byte, no rounding.
    function automatic logic [23:0] dim_grb(input logic [23:0] c, input logic [1:0] sh);
        return {c[23:16] >> sh, c[15:8] >> sh, c[7:0] >> sh};
    endfunction

    assign tick_s   = (ms_q == MS_MAX);
    assign any_s    = |req;
    assign top_s    = top_index(req);
    assign higher_s = any_s && (top_s > gnt_q);

    // Arbitration next state: preemption outranks reassertion, expiry and the tick.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        hold_d    = hold_q;
        restart_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    state_d   = ACTIVE;
                    gnt_d     = top_s;
                    hold_d    = {HOLD_W{1'b0}};
                    restart_s = 1'b1;
                end else begin
                    gnt_d = 2'd0;
                end
            end
            ACTIVE: begin
                if (higher_s) begin
                    gnt_d     = top_s;
                    hold_d    = {HOLD_W{1'b0}};
                    restart_s = 1'b1;
                end else if (!req[gnt_q]) begin
                    state_d = LINGER;
                    hold_d  = HOLD_LOAD;
                end else begin
                    state_d = ACTIVE;
                end
            end
            LINGER: begin
                if (higher_s) begin
                    state_d   = ACTIVE;
                    gnt_d     = top_s;
                    hold_d    = {HOLD_W{1'b0}};
                    restart_s = 1'b1;
                end else if (req[gnt_q]) begin
                    state_d = ACTIVE;
                    hold_d  = {HOLD_W{1'b0}};
                end else if (hold_q == {HOLD_W{1'b0}}) begin
                    // Any pending request here is lower than the grant.
                    if (any_s) begin
                        state_d   = ACTIVE;
                        gnt_d     = top_s;
                        restart_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 2'd0;
                    end
                end else if (tick_s) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'd0;
                hold_d  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // ms prescaler and blink phase; both restart on a grant change so each
    // blink half-period is exactly BLINK_MS ms from the grant.
    always_comb begin
        ms_d    = ms_q;
        blk_d   = blk_q;
        phase_d = phase_q;
        if (restart_s || tick_s) begin
            ms_d = {MS_W{1'b0}};
        end else begin
            ms_d = ms_q + MS_W'(1);
        end
        if (restart_s || (state_d == IDLE)) begin
            blk_d   = {BLINK_W{1'b0}};
            phase_d = 1'b1;
        end else if (tick_s) begin
            if (blk_q == BLINK_MAX) begin
                blk_d   = {BLINK_W{1'b0}};
                phase_d = ~phase_q;
            end else begin
                blk_d = blk_q + BLINK_W'(1);
            end
        end else begin
            blk_d = blk_q;
        end
    end

    // Output values derived from the current registered state.
    always_comb begin
        raw_s   = 24'h000000;
        color_d = 24'h000000;
        case (gnt_q)
            2'd0:    raw_s = color0;
            2'd1:    raw_s = color1;
            2'd2:    raw_s = color2;
            2'd3:    raw_s = color3;
            default: raw_s = 24'h000000;
        endcase
        valid_d = (state_q != IDLE);
        grant_d = valid_d ? gnt_q : 2'd0;
        if (!valid_d || (blink[gnt_q] && !phase_q)) begin
            color_d = 24'h000000;
        end else begin
            color_d = dim_grb(raw_s, dim);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= 2'd0;
            hold_q  <= {HOLD_W{1'b0}};
            ms_q    <= {MS_W{1'b0}};
            blk_q   <= {BLINK_W{1'b0}};
            phase_q <= 1'b1;
            color_q <= 24'h000000;
            grant_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
            ms_q    <= ms_d;
            blk_q   <= blk_d;
            phase_q <= phase_d;
            color_q <= color_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    assign color       = color_q;
    assign grant       = grant_q;
    assign grant_valid = valid_q;

endmodule

// File: tb/tb_ws2812_arbiter.sv
// Self-checking bench for ws2812_arbiter (1 MHz clock parameter, 10 ms
// hold, 4 ms blink). Expected outputs are queued when stimulus is driven
// and compared when the DUT output is due.
module tb_ws2812_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [23:0] color0, color1, color2, color3;
    logic [3:0]  blink;
    logic [1:0]  dim;
    logic [23:0] color;
    logic [1:0]  grant;
    logic        grant_valid;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [23:0] c;
        logic [1:0]  g;
        logic        v;
    } exp_t;

    exp_t exp_q[$];

    ws2812_arbiter #(
        .CLK_FRE (1_000_000),
        .HOLD_MS (10),
        .BLINK_MS(4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .color0     (color0),
        .color1     (color1),
        .color2     (color2),
        .color3     (color3),
        .blink      (blink),
        .dim        (dim),
        .color      (color),
        .grant      (grant),
        .grant_valid(grant_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [23:0] c, input logic [1:0] g, input logic v);
        exp_t e;
        e.tag = tag;
        e.c   = c;
        e.g   = g;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        e = exp_q.pop_front();
        check_eq({e.tag, ".color"}, {8'h00, color}, {8'h00, e.c});
        check_eq({e.tag, ".grant"}, {30'd0, grant}, {30'd0, e.g});
        check_eq({e.tag, ".valid"}, {31'd0, grant_valid}, {31'd0, e.v});
    endtask

    // Queue an expectation for the current stimulus, wait lat edges, compare.
    task automatic expect_out(input string tag, input logic [23:0] c, input logic [1:0] g,
                              input logic v, input int lat);
        push_exp(tag, c, g, v);
        step(lat);
        pop_cmp();
    endtask

    // Wait (bounded) for grant_valid to fall; report elapsed edges.
    task automatic wait_idle(input int max_n, output int n);
        n = 0;
        while (grant_valid === 1'b1 && n < max_n) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        req     = 4'b0000;
        color0  = 24'h00FF00;
        color1  = 24'hABCDEF;
        color2  = 24'h0000FF;
        color3  = 24'h123456;
        blink   = 4'b0000;
        dim     = 2'd0;

        // Reset state
        #2;
        expect_out("reset", 24'h000000, 2'd0, 1'b0, 2);
        reset_n = 1'b1;
        expect_out("idle_noreq", 24'h000000, 2'd0, 1'b0, 3);

        // Single request: two-edge latency to the output
        req = 4'b0001;
        expect_out("grant0_lat1", 24'h000000, 2'd0, 1'b0, 1);
        expect_out("grant0", 24'h00FF00, 2'd0, 1'b1, 1);

        // Higher request preempts
        req = 4'b0101;
        expect_out("preempt2", 24'h0000FF, 2'd2, 1'b1, 2);

        // Lower request does not preempt
        req = 4'b0111;
        expect_out("no_lower_preempt", 24'h0000FF, 2'd2, 1'b1, 20);

        // Dim and colour input changes take one edge
        dim = 2'd2;
        expect_out("dim_live", 24'h00003F, 2'd2, 1'b1, 1);
        dim = 2'd0;
        color2 = 24'h0000F0;
        expect_out("color_live", 24'h0000F0, 2'd2, 1'b1, 1);
        color2 = 24'h0000FF;
        step(1);

        // Release: colour held for about 10 ms, then idle
        req = 4'b0000;
        expect_out("linger_hold", 24'h0000FF, 2'd2, 1'b1, 100);
        wait_idle(15000, n);
        n += 100;
        $display("linger length %0d cycles", n);
        check_eq("linger_len", {31'd0, (n >= 8990 && n <= 11010)}, 32'd1);
        expect_out("after_linger", 24'h000000, 2'd0, 1'b0, 0);

        // Lower request waits for the full hold of the lingering grant
        req = 4'b0100;
        expect_out("grant2_again", 24'h0000FF, 2'd2, 1'b1, 3);
        req = 4'b0001;
        expect_out("lower_waits", 24'h0000FF, 2'd2, 1'b1, 5000);
        n = 5000;
        while (grant === 2'd2 && n < 15000) begin
            step(1);
            n++;
        end
        $display("handover after %0d cycles", n);
        check_eq("handover_len", {31'd0, (n >= 8990 && n <= 11010)}, 32'd1);
        expect_out("handover0", 24'h00FF00, 2'd0, 1'b1, 0);

        // Reassertion during linger returns to ACTIVE with the same grant
        req = 4'b0000;
        expect_out("linger0", 24'h00FF00, 2'd0, 1'b1, 2000);
        req = 4'b0001;
        expect_out("reassert_kept", 24'h00FF00, 2'd0, 1'b1, 12000);

        // Go idle, then blink from a fresh grant
        req = 4'b0000;
        wait_idle(15000, n);
        check_eq("idle_before_blink", {31'd0, grant_valid}, 32'd0);
        blink = 4'b0001;
        req   = 4'b0001;
        expect_out("blink_on0", 24'h00FF00, 2'd0, 1'b1, 2);
        expect_out("blink_on_end", 24'h00FF00, 2'd0, 1'b1, 3999);
        expect_out("blink_off0", 24'h000000, 2'd0, 1'b1, 1);
        expect_out("blink_off_end", 24'h000000, 2'd0, 1'b1, 3999);
        expect_out("blink_on1", 24'h00FF00, 2'd0, 1'b1, 1);

        // Dimming
        blink  = 4'b0000;
        dim    = 2'd2;
        color0 = 24'hFF8040;
        expect_out("dim2", 24'h3F2010, 2'd0, 1'b1, 1);
        dim    = 2'd3;
        color0 = 24'hFFFFFF;
        expect_out("dim3", 24'h1F1F1F, 2'd0, 1'b1, 1);
        dim    = 2'd0;
        color0 = 24'h00FF00;
        step(1);

        // Reset during linger
        req = 4'b0000;
        expect_out("pre_reset_linger", 24'h00FF00, 2'd0, 1'b1, 3000);
        reset_n = 1'b0;
        #2;
        pop_cmp_now("async_reset");
        step(2);
        reset_n = 1'b1;
        expect_out("post_reset_idle", 24'h000000, 2'd0, 1'b0, 12000);
        req = 4'b0001;
        expect_out("post_reset_grant", 24'h00FF00, 2'd0, 1'b1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Compare immediately with no edge (async behaviour).
    task automatic pop_cmp_now(input string tag);
        push_exp(tag, 24'h000000, 2'd0, 1'b0);
        pop_cmp();
    endtask

    // Global guard so the run always terminates.
    initial begin
        #5_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
